// File: rtl/cpu_controller_mc_pkg.sv
// Shared state encodings, select codes and opcode decode masks for the multicycle controller.
package cpu_controller_mc_pkg;

  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,
    S_DECODE = 5'd1,
    S_RIMM   = 5'd2,
    S_RABS1  = 5'd3,
    S_RABS2  = 5'd4,
    S_RADDR  = 5'd5,
    S_EXEC_A = 5'd6,
    S_EXEC_I = 5'd7,
    S_EXEC_J = 5'd8,
    S_WBACK  = 5'd9,
    S_HALT   = 5'd10,
    S_FAULT  = 5'd11
  } state_e;

  localparam logic [1:0] MA_PC  = 2'd0;
  localparam logic [1:0] MA_A   = 2'd1;
  localparam logic [1:0] MA_ALU = 2'd2;

  localparam logic [2:0] SA_PC  = 3'd4;
  localparam logic [2:0] SA_MEM = 3'd5;

  localparam logic [2:0] SB_OP   = 3'd4;
  localparam logic [2:0] SB_ADDR = 3'd5;
  localparam logic [2:0] SB_ONE  = 3'd6;
  localparam logic [2:0] SB_ZERO = 3'd7;

  localparam logic [1:0] DEST_MEM = 2'b11;

  localparam logic [15:0] A_MASK = 16'hF000;
  localparam logic [15:0] A_VAL  = 16'h0000;
  localparam logic [15:0] I_MASK = 16'hC000;
  localparam logic [15:0] I_VAL  = 16'h4000;
  localparam logic [15:0] J_MASK = 16'h8000;
  localparam logic [15:0] J_VAL  = 16'h8000;

  localparam logic [3:0] FUNC_ADD  = 4'b0000;
  localparam logic [3:0] FUNC_JUMP = 4'b0110;

  // Register write enable for A/B/C; the memory destination writes no register.
  function automatic logic [2:0] dest_onehot(input logic [1:0] d);
    return (d == DEST_MEM) ? 3'b000 : 3'(3'b001 << d);
  endfunction

endpackage

// File: rtl/cpu_controller_mc_mem_wait_timer.sv
// Wait-state counter for one memory access; only built with CPU_CTRL_TIMEOUT_EN.
`ifdef CPU_CTRL_TIMEOUT_EN
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)         cnt_d = 8'd0;
    else if (cnt_en_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  // Fires on the waited cycle that brings the count up to LIMIT.
  assign expired_o = cnt_en_i && (cnt_q == 8'(LIMIT - 1));

endmodule
`endif

// File: rtl/cpu_controller_mc.sv
// Multicycle RCPU control FSM with request/ready memory handshake.
// Optional memory-timeout fault enabled by defining CPU_CTRL_TIMEOUT_EN.
module cpu_controller_mc
  import cpu_controller_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int ALU_FUNC_W  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [15:0]           opcode_i,
  input  logic                  memReady_i,
  input  logic                  run_i,
  output logic                  memReq_o,
  output logic                  memWe_o,
  output logic [1:0]            memAddr_o,
  output logic                  enPC_o,
  output logic                  saveOpcode_o,
  output logic                  saveMem_o,
  output logic [ALU_FUNC_W-1:0] aluFunc_o,
  output logic [2:0]            aluA_o,
  output logic [2:0]            aluB_o,
  output logic [2:0]            enReg_o,
  output logic                  halted_o,
  output logic                  fault_o
);

  state_e     state_q, state_d;
  logic [2:0] s1;
  logic       is_a, is_i, is_j;
  logic [2:0] src_a;
  state_e     exec_st;
  logic [3:0] func;
  logic       mem_st;
  logic       expired;
  logic       unused_op;

  assign s1      = opcode_i[11:9];
  assign is_a    = (opcode_i & A_MASK) == A_VAL;
  assign is_i    = (opcode_i & I_MASK) == I_VAL;
  assign is_j    = (opcode_i & J_MASK) == J_VAL;
  assign src_a   = s1[2] ? SA_MEM : {1'b0, s1[1:0]};
  assign exec_st = is_a ? S_EXEC_A : S_EXEC_I;
  assign unused_op = opcode_i[2];

  assign mem_st = (state_q == S_FETCH) || (state_q == S_RIMM)  || (state_q == S_RABS1) ||
                  (state_q == S_RABS2) || (state_q == S_RADDR) || (state_q == S_WBACK);

`ifdef CPU_CTRL_TIMEOUT_EN
  // Clearing on every state change restarts the count on entry to each access.
  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_d != state_q),
    .cnt_en_i  (mem_st && !memReady_i),
    .expired_o (expired)
  );
  assign fault_o = (state_q == S_FAULT);
`else
  logic unused_cfg;
  assign unused_cfg = mem_st | (|8'(MEM_TIMEOUT));
  assign expired    = 1'b0;
  assign fault_o    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    memReq_o     = 1'b0;
    memWe_o      = 1'b0;
    memAddr_o    = MA_PC;
    enPC_o       = 1'b0;
    saveOpcode_o = 1'b0;
    saveMem_o    = 1'b0;
    func         = FUNC_ADD;
    aluA_o       = 3'd0;
    aluB_o       = 3'd0;
    enReg_o      = 3'b000;
    halted_o     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        memReq_o = 1'b1;
        aluA_o   = SA_PC;
        aluB_o   = SB_ONE;
        if (memReady_i) begin
          saveOpcode_o = 1'b1;
          enPC_o       = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_j) state_d = S_EXEC_J;
        else if (is_a || is_i) begin
          unique case (s1)
            3'b100:  state_d = S_RIMM;
            3'b101:  state_d = S_RABS1;
            3'b110:  state_d = S_RADDR;
            3'b111:  state_d = S_HALT;
            default: state_d = exec_st;
          endcase
        end else state_d = S_HALT;
      end
      S_RIMM, S_RABS1: begin
        memReq_o = 1'b1;
        aluA_o   = SA_PC;
        aluB_o   = SB_ONE;
        if (memReady_i) begin
          saveMem_o = 1'b1;
          enPC_o    = 1'b1;
          state_d   = (state_q == S_RABS1) ? S_RABS2 : exec_st;
        end
      end
      S_RABS2: begin
        // Address word fetched in RABS1 passes through the ALU unchanged.
        memReq_o  = 1'b1;
        memAddr_o = MA_ALU;
        aluA_o    = SA_MEM;
        aluB_o    = SB_ZERO;
        if (memReady_i) begin
          saveMem_o = 1'b1;
          state_d   = exec_st;
        end
      end
      S_RADDR: begin
        memReq_o  = 1'b1;
        memAddr_o = MA_A;
        if (memReady_i) begin
          saveMem_o = 1'b1;
          state_d   = exec_st;
        end
      end
      S_EXEC_A: begin
        func   = opcode_i[8:5];
        aluA_o = src_a;
        aluB_o = {1'b0, opcode_i[4:3]};
        if (opcode_i[1:0] == DEST_MEM) begin
          saveMem_o = 1'b1;
          state_d   = S_WBACK;
        end else begin
          enReg_o = dest_onehot(opcode_i[1:0]);
          state_d = S_FETCH;
        end
      end
      S_EXEC_I: begin
        func    = {opcode_i[8], opcode_i[8], opcode_i[13:12]};
        aluA_o  = src_a;
        aluB_o  = SB_OP;
        enReg_o = dest_onehot(s1[1:0]);
        state_d = S_FETCH;
      end
      S_EXEC_J: begin
        func    = FUNC_JUMP;
        aluA_o  = SA_PC;
        aluB_o  = SB_ADDR;
        enPC_o  = 1'b1;
        state_d = S_FETCH;
      end
      S_WBACK: begin
        memReq_o  = 1'b1;
        memWe_o   = 1'b1;
        memAddr_o = MA_A;
        aluB_o    = SB_ZERO;
        if (memReady_i) state_d = S_FETCH;
      end
      S_HALT: begin
        halted_o = 1'b1;
        if (run_i) state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
    // expired only fires with memReady low, so every enable is already 0 here.
    if (expired) state_d = S_FAULT;
  end

  assign aluFunc_o = ALU_FUNC_W'(func);

endmodule

// File: doc/cpu_controller_mc.md
# cpu_controller_mc

Multicycle CPU control FSM for the RCPU core. It sequences instruction fetch, operand reads in each addressing mode, execution and an optional memory write-back. Every memory access uses a request/ready handshake, so the core can sit on memory with arbitrary wait states. It drives the same datapath select and enable buses as the single-cycle-memory controller, and adds a memory-store destination, a resumable halt, and an optional memory-timeout fault.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum cycles one memory access may wait for `memReady`. Legal range 1..255.
- `ALU_FUNC_W`, default 4: width of `aluFunc`.

Ports:
- `clk` input 1: clock. One clock domain only.
- `rst` input 1: reset, synchronous and active-low. Sampled on the rising edge of `clk`.
- `opcode` input 16: instruction register contents.
- `memReady` input 1: memory completes the current access this cycle.
- `run` input 1: single-cycle pulse that resumes execution from HALT.
- `memReq` output 1: memory access requested.
- `memWe` output 1: the current request is a write.
- `memAddr` output 2: address source. PC=0, A=1, ALU=2.
- `enPC` output 1: program counter write enable.
- `saveOpcode` output 1: instruction register write enable.
- `saveMem` output 1: internal value register write enable.
- `aluFunc` output ALU_FUNC_W: ALU control.
- `aluA` output 3: ALU input A source. Reg 0..3 is 0..3, PC=4, MEM=5.
- `aluB` output 3: ALU input B source. Reg 0..3 is 0..3, OP=4, ADDR=5, ONE=6, ZERO=7.
- `enReg` output 3: one-hot write enable for A/B/C.
- `halted` output 1: FSM is in HALT.
- `fault` output 1: FSM is in FAULT (memory timeout).

## Operation
- Opcode fields:
  - s1 = [11:9]
  - A-type: [15:12]=0000. Fields are aluFunc=[8:5], aluB=[4:3], dest=[1:0].
  - I-type: [15:14]=01. aluFunc={op[8],op[8],op[13:12]}, aluB=OP, dest=s1.
  - J-type: [15]=1. Computes PC + ADDR with aluFunc 0110 and writes PC.
  - Any other opcode is invalid and goes to HALT.
- Read mode, for A-type and I-type only:
  - s1[2]=0 reads a register; aluA=s1[1:0].
  - s1=100 reads an immediate (RIMM).
  - s1=101 reads an absolute address (RABS1 then RABS2).
  - s1=110 reads through address A (RADDR).
  - s1=111 is invalid and goes to HALT.
  - Any memory read mode sets aluA=MEM.
- States and transitions:
  - FETCH → DECODE on memReady.
  - DECODE → RIMM/RABS1/RADDR when a memory read is needed; otherwise the EXEC state for the type, or HALT.
  - RIMM, RADDR, RABS2 → EXEC on memReady.
  - RABS1 → RABS2 on memReady.
  - EXEC_A → WBACK if dest=11, else FETCH.
  - EXEC_I and EXEC_J → FETCH.
  - WBACK → FETCH on memReady.
  - HALT → FETCH when run=1.
  - FAULT: stays there until reset.
- Memory states are FETCH, RIMM, RABS1, RABS2, RADDR and WBACK.
  - In these states memReq=1 and the address selects are held stable until memReady.
  - saveOpcode, saveMem and enPC assert only in the cycle where memReady=1.
- Per-state outputs (all non-listed outputs are 0):
  - FETCH: memAddr=PC, saveOpcode, enPC with PC+1 (aluA=PC, aluB=ONE, func 0).
  - RIMM and RABS1: memAddr=PC, saveMem, enPC with PC+1.
  - RABS2: memAddr=ALU, aluA=MEM, aluB=ZERO, func 0, saveMem.
  - RADDR: memAddr=A, saveMem.
  - EXEC_A, EXEC_I: enReg from dest (dest 11 writes no register). EXEC_J: enPC.
  - WBACK: memWe=1, memAddr=A, aluA=aluB=ZERO... the ALU result from EXEC is held in the value register.
- EXEC_A with dest=11 asserts saveMem instead of enReg, so WBACK writes that value.

## Timing
- Reset:
  - rst low at a clock edge puts the FSM in FETCH.
  - With FSM in FETCH, outputs are memReq=1, memAddr=0, halted=0, fault=0. saveOpcode and enPC stay 0 until memReady.
  - Reset mid-access abandons the access without any enable pulse.
- Latency with zero wait states (memReady tied high):
  - Register-operand instruction: 3 cycles.
  - RIMM or RADDR: 4 cycles.
  - Absolute read: 5 cycles.
  - A-type with dest=11: +1 cycle for WBACK.
- All outputs are combinational from state, memReady and opcode.
- The wait counter clears on entry to each memory state. It counts every cycle that memReq=1 and memReady=0.
- memReady outside memory states is ignored.
- run outside HALT is ignored. run arriving on the same edge as the HALT entry is ignored.

## Configuration
- `CPU_CTRL_TIMEOUT_EN` defined:
  - If the count reaches MEM_TIMEOUT while memReady=0, the next state is FAULT.
  - The access is dropped: memReq=0, fault=1, all enables 0.
  - memReady on the same cycle the count reaches MEM_TIMEOUT wins; no fault.
- Undefined: the FSM waits indefinitely, fault is tied 0, and no counter is instantiated.

## Structure
- Shared constants file gains:
  - State encodings (5-bit).
  - memAddr, aluA and aluB select codes.
  - DEST_MEM=2'b11.
  - Type-decode masks.
- One sub-module, `mem_wait_timer`, holding the clear/count/expired logic. It is present only under `CPU_CTRL_TIMEOUT_EN`.

## Test plan
- Register A-type, memReady=1: opcode 0x002A → FETCH, DECODE, EXEC_A. In EXEC_A: aluA=0, aluB=1, aluFunc=0001, enReg=100. Back in FETCH on cycle 4.
- Immediate with 2 wait states: opcode 0x082A, memReady low for 2 cycles in RIMM. saveMem and enPC pulse exactly once, on the ready cycle. EXEC_A has aluA=5.
- Write-back: opcode 0x002B. EXEC_A asserts saveMem with enReg=000. WBACK asserts memReq=1, memWe=1, memAddr=1.
- Invalid opcode 0x2000 → halted=1. Holding run=0 for 5 cycles keeps the FSM in HALT. A run pulse → FETCH on the next cycle.
- Timeout (macro on, MEM_TIMEOUT=3): memReady held 0 in FETCH → fault=1 after 3 waited cycles, with no saveOpcode. fault stays high until rst=0.
- Reset mid-RABS2 → next cycle in FETCH with saveMem=0. No stray enPC.
